// File: rtl/seq_det_param.sv
// seq_det_param: runtime-programmable serial pattern detector with overlap control and saturating match count
module seq_det_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] PAT_RST = 8'b0001_1011,
    parameter logic [LEN_W-1:0]   LEN_RST = 5,
    parameter logic               OVL_RST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               ovl_in,
    output logic               det,
    output logic               det_r,
    output logic [CNT_W-1:0]   det_cnt,
    output logic               cfg_ok
);
    logic [MAX_LEN-1:0] hist, pattern, window, mask;
    logic [LEN_W-1:0]   len, fill;
    logic               ovl, fill_ok;
    assign window  = {hist[MAX_LEN-2:0], inp};
    assign cfg_ok  = len >= LEN_W'(2) && len <= LEN_W'(MAX_LEN);
    assign fill_ok = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len};
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len;
    end
    assign det = !rst && !cfg_load && cfg_ok && fill_ok && ((window ^ pattern) & mask) == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= PAT_RST;
            len     <= LEN_RST;
            ovl     <= OVL_RST;
            hist    <= '0;
            fill    <= '0;
            det_r   <= 1'b0;
            det_cnt <= '0;
        end else if (cfg_load) begin
            pattern <= pat_in;
            len     <= len_in;
            ovl     <= ovl_in;
            fill    <= '0;
            det_r   <= 1'b0;
        end else begin
            hist    <= window;
            fill    <= (det && !ovl) ? '0 : (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
            det_r   <= det;
            det_cnt <= (det && !(&det_cnt)) ? det_cnt + CNT_W'(1) : det_cnt;
        end
    end
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: table-driven, directed and randomized checks of seq_det_param against a queue-based model
module tb_seq_det_param;
    logic       clk = 1'b0;
    logic       rst, inp, cfg_load, ovl_in;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       det, det_r, cfg_ok, det2, det_r2, cfg_ok2;
    logic [7:0] det_cnt;
    logic [1:0] cnt2;

    seq_det_param dut (
        .clk(clk), .rst(rst), .inp(inp), .cfg_load(cfg_load), .pat_in(pat_in),
        .len_in(len_in), .ovl_in(ovl_in), .det(det), .det_r(det_r),
        .det_cnt(det_cnt), .cfg_ok(cfg_ok)
    );
    seq_det_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .inp(inp), .cfg_load(cfg_load), .pat_in(pat_in),
        .len_in(len_in), .ovl_in(ovl_in), .det(det2), .det_r(det_r2),
        .det_cnt(cnt2), .cfg_ok(cfg_ok2)
    );

    always #5 clk = ~clk;

    int    n_vec = 0, n_chk = 0, n_err = 0;
    string ph = "init";

    // reference model: bits received since the last clear, oldest first
    logic  q[$];
    logic [7:0] m_pat;
    int    m_len, m_cnt8, m_cnt2;
    logic  m_ovl, m_dr;
    logic  s_det, s_dr, s_ok;
    logic [7:0] s_cnt;
    logic [1:0] s_cnt2;

    typedef struct {
        logic [2:0] ctl;
        logic [7:0] p;
        logic [3:0] ln;
        logic       o;
        logic [1:0] e;
        logic [7:0] ec;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input logic [2:0] ctl, input logic [7:0] p, input logic [3:0] ln,
                     input logic o, input logic [1:0] e, input logic [7:0] ec);
        vec_t t;
        t.ctl = ctl; t.p = p; t.ln = ln; t.o = o; t.e = e; t.ec = ec;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s at %0t: got %0h expected %0h", ph, name, $time, act, exp);
        end
    endtask

    function automatic logic m_valid();
        return m_len >= 2 && m_len <= 8;
    endfunction

    function automatic logic m_det_f(input logic r, input logic l, input logic b);
        logic s;
        if (r || l || !m_valid()) return 1'b0;
        if (q.size() < m_len - 1) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (k == 0) s = b;
            else s = q[q.size() - k];
            if (s !== m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        q.delete();
        m_pat = 8'h1B; m_len = 5; m_ovl = 1'b1; m_dr = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic step(input logic r, input logic l, input logic b,
                        input logic [7:0] p, input logic [3:0] ln, input logic o);
        logic ed;
        @(negedge clk);
        rst = r; cfg_load = l; inp = b; pat_in = p; len_in = ln; ovl_in = o;
        #1;
        ed = m_det_f(r, l, b);
        n_vec++;
        s_det = det; s_dr = det_r; s_cnt = det_cnt; s_cnt2 = cnt2; s_ok = cfg_ok;
        chk("det", det, ed);
        chk("det_r", det_r, m_dr);
        chk("det_cnt", det_cnt, m_cnt8);
        chk("det_cnt2", cnt2, m_cnt2);
        chk("cfg_ok", cfg_ok, m_valid());
        @(posedge clk);
        if (r) m_reset();
        else if (l) begin
            m_pat = p; m_len = ln; m_ovl = o; m_dr = 1'b0; q.delete();
        end else begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            if (ed && !m_ovl) q.delete();
            m_dr = ed;
            if (ed && m_cnt8 < 255) m_cnt8++;
            if (ed && m_cnt2 < 3) m_cnt2++;
        end
    endtask

    initial begin
        logic [7:0] bits;
        rst = 1'b1; cfg_load = 1'b0; inp = 1'b0; pat_in = '0; len_in = '0; ovl_in = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();

        // reset defaults 11011/5/overlap, then non-overlap reload, history clear on load, mid-stream reset
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b10, 8'd0);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b01, 8'd1);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd1);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b10, 8'd1);
        v(3'b010, 8'h1B, 4'd5, 1'b0, 2'b01, 8'd2);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd2);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd2);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd2);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd2);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b10, 8'd2);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b01, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b011, 8'h0B, 4'd4, 1'b1, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b10, 8'd3);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b01, 8'd4);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd4);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd4);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd4);
        v(3'b100, 8'h00, 4'd0, 1'b0, 2'b00, 8'd4);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b000, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b00, 8'd0);
        v(3'b001, 8'h00, 4'd0, 1'b0, 2'b10, 8'd0);
        ph = "table";
        foreach (tbl[i]) begin
            step(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].p, tbl[i].ln, tbl[i].o);
            chk("tbl_det", s_det, tbl[i].e[1]);
            chk("tbl_det_r", s_dr, tbl[i].e[0]);
            chk("tbl_cnt", s_cnt, tbl[i].ec);
        end

        // pattern 11 in overlap mode on a run of ones: det every cycle, 2-bit count saturates
        ph = "sat";
        step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h03, 4'd2, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b0, i <= 6, 8'h00, 4'd0, 1'b0);
            chk("run_det", s_det, i >= 2 && i <= 6);
            chk("run_cnt2", s_cnt2, (i <= 2) ? 0 : (i - 2 > 3) ? 3 : i - 2);
        end

        // invalid lengths keep det low; then a full-width pattern
        ph = "len";
        for (int t = 0; t < 2; t++) begin
            step(1'b0, 1'b1, 1'b0, 8'h01, (t == 0) ? 4'd1 : 4'd9, 1'b1);
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
                chk("bad_ok", s_ok, 1'b0);
                chk("bad_det", s_det, 1'b0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 8'hA5, 4'd8, 1'b1);
        bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, bits[7-i], 8'h00, 4'd0, 1'b0);
            chk("full_ok", s_ok, 1'b1);
            chk("full_det", s_det, i == 7);
        end

        ph = "random";
        for (int i = 0; i < 4000; i++) begin
            logic r, l;
            r = $urandom_range(0, 299) == 0;
            l = !r && $urandom_range(0, 39) == 0;
            step(r, l, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 4)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
